// File: rtl/pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Holds the program counter and fetches one instruction at a time from the
// instruction memory over a req/ack handshake. The fetched word is presented
// to decode, and the PC advances only when decode consumes it. A branch or
// jump redirect loads a new target instead. A redirect that arrives while a
// fetch is outstanding is remembered, and the fetch that was in flight is
// discarded when it completes.
//
// Ports:
//   clock            rising-edge clock
//   reset            synchronous active-high reset, wins over everything
//   run              enable fetching; 0 parks in IDLE at an instruction boundary
//   stall            decode cannot accept the presented instruction this cycle
//   redirect_valid   single-cycle pulse: redirect_target becomes the next PC
//   redirect_target  branch/jump destination
//   imem_req         fetch request, held stable until imem_ack
//   imem_addr        fetch address (equals pc while imem_req=1)
//   imem_ack         memory accepted request; imem_rdata valid this cycle
//   imem_rdata       instruction word returned with imem_ack
//   instr_valid      instr / instr_pc valid for decode
//   instr            captured instruction
//   instr_pc         address the captured instruction was fetched from
//   pc               current program counter
// ---------------------------------------------------------------------------
module pc_fetch_sequencer #(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  INC      = ADDR_W'(32'd1),
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(32'd0)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [ADDR_W-1:0]  pc_r;
    logic [ADDR_W-1:0]  pc_s;
    logic [31:0]        instr_r;
    logic [31:0]        instr_s;
    logic [ADDR_W-1:0]  instr_pc_r;
    logic [ADDR_W-1:0]  instr_pc_s;
    logic               pend_r;
    logic               pend_s;
    logic [ADDR_W-1:0]  target_r;
    logic [ADDR_W-1:0]  target_s;
    logic               req_r;
    logic               valid_r;

    // Next-state and datapath decisions for the fetch sequencer.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        instr_s    = instr_r;
        instr_pc_s = instr_pc_r;
        pend_s     = pend_r;
        target_s   = target_r;

        case (state_r)
            ST_IDLE: begin
                if (redirect_valid) begin
                    pc_s    = redirect_target;
                    state_s = ST_IDLE;
                end else if (run) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_REQ: begin
                if (imem_ack) begin
                    if (pend_r || redirect_valid) begin
                        // The in-flight fetch is stale: drop its data and
                        // restart at the newest redirect target.
                        pc_s    = redirect_valid ? redirect_target : target_r;
                        pend_s  = 1'b0;
                        state_s = run ? ST_REQ : ST_IDLE;
                    end else begin
                        instr_s    = imem_rdata;
                        instr_pc_s = pc_r;
                        state_s    = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    // The request cannot be withdrawn, so remember where to
                    // go once it completes. A later redirect overwrites this.
                    target_s = redirect_target;
                    pend_s   = 1'b1;
                end else begin
                    state_s = ST_REQ;
                end
            end

            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_s    = redirect_target;
                    state_s = run ? ST_REQ : ST_IDLE;
                end else if (!stall) begin
                    pc_s    = pc_r + INC;
                    state_s = run ? ST_REQ : ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, PC, captured instruction and registered handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_PC;
            instr_r    <= '0;
            instr_pc_r <= '0;
            pend_r     <= 1'b0;
            target_r   <= '0;
            req_r      <= 1'b0;
            valid_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            instr_r    <= instr_s;
            instr_pc_r <= instr_pc_s;
            pend_r     <= pend_s;
            target_r   <= target_s;
            // Flags are computed from the next state so they leave the
            // block straight from flops.
            req_r      <= (state_s == ST_REQ);
            valid_r    <= (state_s == ST_HOLD);
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign instr_valid = valid_r;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign pc          = pc_r;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// Self-checking bench for pc_fetch_sequencer.
// dut0 (RESET_PC=0) is checked every cycle against a behavioural model plus
// hand-computed literals; dut1 (RESET_PC=all-ones) covers the PC wrap and a
// mid-request reset with literal expectations only.
// ---------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

    localparam int unsigned AW = 32;
    localparam logic [31:0] MEM_KEY = 32'hC0DE_0000;

    logic          clock;
    logic          reset, run, stall, redirect_valid;
    logic [AW-1:0] redirect_target;
    logic          imem_req, imem_ack, instr_valid;
    logic [AW-1:0] imem_addr, instr_pc, pc;
    logic [31:0]   imem_rdata, instr;

    logic          reset1, run1, stall1, rv1, ack1;
    logic [AW-1:0] rt1;
    logic          req1, valid1;
    logic [AW-1:0] addr1, ipc1, pc1;
    logic [31:0]   rdata1, instr1;

    int n_checks = 0;
    int n_errors = 0;

    // memory model: word at address a is MEM_KEY ^ a
    assign imem_rdata = MEM_KEY ^ imem_addr;
    assign rdata1     = 32'h1234_5678;

    pc_fetch_sequencer #(.ADDR_W(AW), .INC(32'd1), .RESET_PC(32'd0)) dut0 (
        .clock(clock), .reset(reset), .run(run), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .pc(pc)
    );

    pc_fetch_sequencer #(.ADDR_W(AW), .INC(32'd1), .RESET_PC(32'hFFFF_FFFF)) dut1 (
        .clock(clock), .reset(reset1), .run(run1), .stall(stall1),
        .redirect_valid(rv1), .redirect_target(rt1),
        .imem_req(req1), .imem_addr(addr1), .imem_ack(ack1),
        .imem_rdata(rdata1), .instr_valid(valid1), .instr(instr1),
        .instr_pc(ipc1), .pc(pc1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model of dut0 ----------------
    logic          m_known, m_fetching, m_presenting, m_pend;
    logic [AW-1:0] m_pc, m_ptgt, m_ipc;
    logic [31:0]   m_instr;

    initial begin
        m_known = 1'b0; m_fetching = 1'b0; m_presenting = 1'b0; m_pend = 1'b0;
        m_pc = '0; m_ptgt = '0; m_ipc = '0; m_instr = '0;
        forever begin
            @(posedge clock);
            if (reset) begin
                m_known = 1'b1; m_fetching = 1'b0; m_presenting = 1'b0;
                m_pend = 1'b0; m_pc = '0; m_instr = '0; m_ipc = '0;
            end else if (m_presenting) begin
                if (redirect_valid || !stall) begin
                    m_pc = redirect_valid ? redirect_target : m_pc + 32'd1;
                    m_presenting = 1'b0;
                    m_fetching = run;
                end
            end else if (m_fetching) begin
                if (imem_ack) begin
                    if (m_pend || redirect_valid) begin
                        m_pc = redirect_valid ? redirect_target : m_ptgt;
                        m_pend = 1'b0;
                        m_fetching = run;
                    end else begin
                        m_instr = MEM_KEY ^ m_pc;
                        m_ipc = m_pc;
                        m_fetching = 1'b0;
                        m_presenting = 1'b1;
                    end
                end else if (redirect_valid) begin
                    m_ptgt = redirect_target;
                    m_pend = 1'b1;
                end
            end else begin
                if (redirect_valid) m_pc = redirect_target;
                else if (run) m_fetching = 1'b1;
            end
            @(negedge clock);
            if (m_known) begin
                chk("m_imem_req", 64'(imem_req), 64'(m_fetching));
                if (m_fetching) chk("m_imem_addr", 64'(imem_addr), 64'(m_pc));
                chk("m_instr_valid", 64'(instr_valid), 64'(m_presenting));
                chk("m_instr", 64'(instr), 64'(m_instr));
                chk("m_instr_pc", 64'(instr_pc), 64'(m_ipc));
                chk("m_pc", 64'(pc), 64'(m_pc));
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b1; run = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        redirect_target = '0; imem_ack = 1'b0;
        reset1 = 1'b1; run1 = 1'b0; stall1 = 1'b0; rv1 = 1'b0; rt1 = '0; ack1 = 1'b0;
        step(2);
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_instr_pc", 64'(instr_pc), 64'd0);
        reset1 = 1'b0;

        // sequential fetch, ack every request cycle
        reset = 1'b0; run = 1'b1; imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("seq_req", 64'(imem_req), 64'd1);
            chk("seq_addr", 64'(imem_addr), 64'(i));
            step(1);
            chk("seq_valid", 64'(instr_valid), 64'd1);
            chk("seq_instr_pc", 64'(instr_pc), 64'(i));
            chk("seq_instr", 64'(instr), 64'(32'hC0DE_0000 + i));
        end
        step(2);                       // consume 3, fetch 4 -> HOLD(4)
        imem_ack = 1'b0;
        step(1);                       // consume 4 -> REQ at 5
        for (int i = 0; i < 4; i++) begin
            chk("late_req", 64'(imem_req), 64'd1);
            chk("late_addr", 64'(imem_addr), 64'd5);
            chk("late_valid", 64'(instr_valid), 64'd0);
            if (i == 3) imem_ack = 1'b1;
            step(1);
        end
        chk("late_valid_after_ack", 64'(instr_valid), 64'd1);
        chk("late_instr", 64'(instr), 64'h0000_0000_C0DE_0005);

        // stall for 4 cycles
        imem_ack = 1'b0; stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("stall_valid", 64'(instr_valid), 64'd1);
            chk("stall_instr", 64'(instr), 64'h0000_0000_C0DE_0005);
            chk("stall_pc", 64'(pc), 64'd5);
        end
        stall = 1'b0;
        step(1);
        chk("release_pc", 64'(pc), 64'd6);
        chk("model_pin_pc6", 64'(m_pc), 64'd6);
        imem_ack = 1'b1;
        step(3);                       // HOLD(6), consume -> REQ 7, HOLD(7)
        chk("hold7_instr_pc", 64'(instr_pc), 64'd7);

        // redirect during HOLD
        imem_ack = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h40;
        step(1);
        redirect_valid = 1'b0;
        chk("rdh_valid", 64'(instr_valid), 64'd0);
        chk("rdh_addr", 64'(imem_addr), 64'h40);
        chk("model_pin_pc40", 64'(m_pc), 64'h40);
        imem_ack = 1'b1;
        step(1);
        chk("rdh_instr_pc", 64'(instr_pc), 64'h40);

        // redirect during REQ before a late ack
        imem_ack = 1'b0; redirect_valid = 1'b1; redirect_target = 32'd9;
        step(1);                       // HOLD -> REQ at 9
        redirect_target = 32'h80;
        step(1);                       // pending 0x80
        redirect_valid = 1'b0;
        chk("rdr_addr", 64'(imem_addr), 64'd9);
        chk("rdr_pc", 64'(pc), 64'd9);
        step(1);
        imem_ack = 1'b1;
        step(1);                       // ack discarded -> REQ at 0x80
        chk("rdr_valid", 64'(instr_valid), 64'd0);
        chk("rdr_req", 64'(imem_req), 64'd1);
        chk("rdr_addr2", 64'(imem_addr), 64'h80);
        step(1);
        chk("rdr_instr_pc", 64'(instr_pc), 64'h80);

        // two redirects while pending: last wins; then redirect coincident with ack
        imem_ack = 1'b0;
        step(1);                       // REQ at 0x81
        redirect_valid = 1'b1; redirect_target = 32'h100;
        step(1);
        redirect_target = 32'h200;
        step(1);
        redirect_valid = 1'b0; imem_ack = 1'b1;
        step(1);
        chk("lastwins_addr", 64'(imem_addr), 64'h200);
        redirect_valid = 1'b1; redirect_target = 32'h300;
        step(1);
        redirect_valid = 1'b0;
        chk("ackrd_addr", 64'(imem_addr), 64'h300);
        chk("ackrd_valid", 64'(instr_valid), 64'd0);
        step(1);                       // HOLD(0x300)

        // run deassert in HOLD, IDLE redirect, run deassert in REQ
        run = 1'b0; stall = 1'b1;
        step(1);
        chk("rund_hold_valid", 64'(instr_valid), 64'd1);
        stall = 1'b0;
        step(2);
        chk("rund_idle_req", 64'(imem_req), 64'd0);
        chk("rund_idle_pc", 64'(pc), 64'h301);
        redirect_valid = 1'b1; redirect_target = 32'h10;
        step(1);
        redirect_valid = 1'b0;
        chk("idle_rd_pc", 64'(pc), 64'h10);
        chk("idle_rd_req", 64'(imem_req), 64'd0);
        run = 1'b1; imem_ack = 1'b0;
        step(1);
        run = 1'b0;
        step(1);
        chk("rund_req_held", 64'(imem_req), 64'd1);
        imem_ack = 1'b1;
        step(1);
        chk("rund_req_done", 64'(instr_pc), 64'h10);
        step(1);
        chk("rund_final_pc", 64'(pc), 64'h11);

        // reset in mid-request
        run = 1'b1; imem_ack = 1'b0;
        step(1);
        chk("mid_req", 64'(imem_req), 64'd1);
        reset = 1'b1;
        step(1);
        reset = 1'b0; run = 1'b0; imem_ack = 1'b1;
        chk("mid_rst_req", 64'(imem_req), 64'd0);
        chk("mid_rst_pc", 64'(pc), 64'd0);
        step(2);
        chk("mid_rst_late_ack", 64'(instr_valid), 64'd0);

        // dut1: all-ones reset PC wraps to 0
        chk("w_rst_pc", 64'(pc1), 64'hFFFF_FFFF);
        run1 = 1'b1; ack1 = 1'b1;
        step(1);
        chk("w_addr", 64'(addr1), 64'hFFFF_FFFF);
        step(1);
        chk("w_valid", 64'(valid1), 64'd1);
        chk("w_instr", 64'(instr1), 64'h1234_5678);
        ack1 = 1'b0;
        step(1);
        chk("w_pc", 64'(pc1), 64'd0);
        chk("w_req", 64'(req1), 64'd1);
        reset1 = 1'b1;
        step(1);
        chk("w_rst_req", 64'(req1), 64'd0);
        chk("w_rst_pc2", 64'(pc1), 64'hFFFF_FFFF);
        chk("w_rst_valid", 64'(valid1), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Sequences the program counter against the instruction memory.
- Holds the PC, issues one fetch request per instruction over a req/ack handshake, and presents the fetched instruction to decode.
- Advances the PC once decode consumes the instruction, or loads a redirect target for branches and jumps.
- Sits between the PC register path and the decode stage, and replaces the free-running PC increment with handshake-driven advance.

Parameters:
ADDR_W, 32, width of PC and memory address
INC, 1, PC increment per instruction (word-addressed)
RESET_PC, 0, PC value loaded on reset

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
run  input  1  enable fetching; 0 parks sequencer in IDLE at instruction boundary
stall  input  1  decode cannot accept presented instruction this cycle
redirect_valid  input  1  single-cycle pulse: load redirect_target as next PC
redirect_target  input  ADDR_W  branch/jump destination
imem_req  output  1  fetch request to instruction memory
imem_addr  output  ADDR_W  fetch address, equals pc while imem_req=1
imem_ack  input  1  memory accepted request; imem_rdata valid this cycle
imem_rdata  input  32  instruction word, valid when imem_ack=1
instr_valid  output  1  instr/instr_pc valid for decode
instr  output  32  captured instruction
instr_pc  output  ADDR_W  address instr was fetched from
pc  output  ADDR_W  current program counter

Behaviour:
- Reset (sync, active-high, wins over everything):
  - state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, redirect_pending=0.
  - Reset in mid-request abandons the request; a later ack is ignored, because acks count only while imem_req=1.
- States:
  - IDLE: imem_req=0, instr_valid=0.
    - redirect_valid: pc<=redirect_target and stay in IDLE.
    - else run=1: go to REQ next cycle.
  - REQ: imem_req=1, imem_addr=pc, and both stay stable until ack. Request is never withdrawn.
    - imem_ack=1 and redirect pending (redirect_pending=1, or redirect_valid this cycle): discard rdata, pc<=target, clear pending, go to REQ if run=1, else IDLE.
    - imem_ack=1 with no redirect: instr<=imem_rdata, instr_pc<=pc, go to HOLD.
    - imem_ack=0 and redirect_valid: latch target, set redirect_pending, stay in REQ at the old address.
  - HOLD: instr_valid=1, and instr/instr_pc stay stable.
    - redirect_valid (highest priority): pc<=redirect_target, instr_valid falls next cycle, go to REQ if run=1, else IDLE.
    - else stall=0 (consumed): pc<=pc+INC, go to REQ if run=1, else IDLE.
    - else stall=1: hold everything.
- Latency:
  - Ack in the first REQ cycle gives instr_valid on the next cycle.
  - Peak throughput is 1 instruction per 2 cycles.
- Arithmetic: pc+INC is modulo 2^ADDR_W, so all-ones+1 wraps to 0 with no flag.
- The second redirect_valid while redirect_pending=1 overwrites the latched target (last wins).
- run deassert:
  - In REQ: the request completes first.
  - In HOLD: takes effect after consume or redirect.
  - No instruction is dropped.
- pc changes only on consume, redirect, or reset. It is never incremented by a discarded fetch.

Test Plan:
- Reset then run=1, imem_ack=1 every REQ cycle, stall=0: imem_addr sequence 0,1,2,3 on alternating cycles; instr_valid pulses with instr_pc 0,1,2,3.
- Ack delayed 3 cycles at pc=5: imem_req/imem_addr=5 held 4 cycles; instr_valid asserts the cycle after ack with instr=rdata.
- HOLD with stall=1 for 4 cycles, then stall=0: instr and pc unchanged while stalled; pc increments by 1 exactly once after release.
- redirect_valid (target 0x40) during HOLD at pc=7: instr_valid drops next cycle; next imem_addr=0x40; no fetch from 8.
- redirect_valid (target 0x80) during REQ before a late ack at pc=9: ack data discarded (instr_valid stays 0); next request at 0x80.
- RESET_PC=32'hFFFFFFFF, consume one instruction: next pc=0. Assert reset mid-REQ: next cycle imem_req=0, pc=RESET_PC, instr_valid=0.
